// File: rtl/cpu_types_pkg.sv
// Shared CPU types: IF/ID payload width and the pipeline latch state.
// Imported by the latch and by any stage that instantiates it.
package cpu_types_pkg;

    localparam int IFID_W = 64;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } latch_state_t;

endpackage

// File: rtl/pipe_skid_latch.sv
// Two-entry pipeline latch (main + skid) with registered in_ready,
// flush, optional bubble zeroing and a saturating stall counter.
module pipe_skid_latch
    import cpu_types_pkg::*;
#(
    parameter int WIDTH       = IFID_W,
    parameter bit ZERO_BUBBLE = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    latch_state_t     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic acc;
    logic cons;

    // Ready depends on state alone so out_ready never reaches in_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

    assign out_data = (ZERO_BUBBLE && !out_valid) ? '0 : main_q;

    assign acc  = in_valid && in_ready;
    assign cons = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (flush) begin
            state_d = EMPTY;
            if (ZERO_BUBBLE) begin
                main_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (acc && cons) begin
                        main_d = in_data;
                    end else if (acc) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (cons) begin
                        state_d = EMPTY;
                        if (ZERO_BUBBLE) begin
                            main_d = '0;
                        end
                    end
                end
                FULL: begin
                    if (cons) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed and queue-model checks for pipe_skid_latch (CNT_W=4).
// Inputs change #1 after the rising edge; outputs are checked there.
module tb_pipe_skid_latch;
    import cpu_types_pkg::*;

    localparam int W  = IFID_W;
    localparam int CW = 4;

    logic          CLK;
    logic          nRST;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          flush;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] q[$];

    pipe_skid_latch #(
        .WIDTH(W),
        .ZERO_BUBBLE(1'b1),
        .CNT_W(CW)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .flush(flush),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [63:0] d, input logic [1:0] occ,
                           input logic rdy);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".data"}, out_data, d);
        chk({tag, ".occ"}, 64'(occupancy), 64'(occ));
        chk({tag, ".ready"}, 64'(in_ready), 64'(rdy));
    endtask

    initial begin
        logic         ex_rdy;
        logic         a;
        logic         c;
        logic [W-1:0] d;

        nRST      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #12;
        chk_out("reset", 1'b0, 64'h0, 2'd0, 1'b1);
        chk("reset.stall", 64'(stall_cnt), 64'd0);
        nRST = 1'b1;
        step();

        // Single payload, latency 1
        in_valid  = 1'b1;
        in_data   = 64'h00000004_8C220000;
        out_ready = 1'b1;
        step();
        chk_out("lat1", 1'b1, 64'h000000048C220000, 2'd1, 1'b1);
        in_valid = 1'b0;
        step();
        chk_out("lat1.drain", 1'b0, 64'h0, 2'd0, 1'b1);
        chk("lat1.stall", 64'(stall_cnt), 64'd0);

        // Fill to FULL, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hAAAA_0000_0000_0001;
        step();
        chk_out("fill.a", 1'b1, 64'hAAAA_0000_0000_0001, 2'd1, 1'b1);
        in_data = 64'hBBBB_0000_0000_0002;
        step();
        chk_out("fill.b", 1'b1, 64'hAAAA_0000_0000_0001, 2'd2, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk_out("drain.b", 1'b1, 64'hBBBB_0000_0000_0002, 2'd1, 1'b1);
        step();
        chk_out("drain.e", 1'b0, 64'h0, 2'd0, 1'b1);
        chk("drain.stall", 64'(stall_cnt), 64'd1);

        // Flush while FULL with a same-cycle accept attempt
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hCCCC_0000_0000_0003;
        step();
        in_data = 64'hDDDD_0000_0000_0004;
        step();
        chk_out("flush.full", 1'b1, 64'hCCCC_0000_0000_0003, 2'd2, 1'b0);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 64'hEEEE_0000_0000_0005;
        step();
        chk_out("flush.now", 1'b0, 64'h0, 2'd0, 1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk_out("flush.after", 1'b0, 64'h0, 2'd0, 1'b1);
        chk("flush.stall", 64'(stall_cnt), 64'd2);

        // ONE with accept and consume stays in ONE
        in_valid = 1'b1;
        in_data  = 64'h1111_0000_0000_0006;
        step();
        in_data = 64'h2222_0000_0000_0007;
        step();
        chk_out("pass", 1'b1, 64'h2222_0000_0000_0007, 2'd1, 1'b1);
        in_valid = 1'b0;
        step();
        chk_out("pass.e", 1'b0, 64'h0, 2'd0, 1'b1);

        // Stall counter saturates at 15
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 64'h3333_0000_0000_0008;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat.stall", 64'(stall_cnt), 64'd15);
        step();
        chk("sat.hold", 64'(stall_cnt), 64'd15);
        chk_out("sat.data", 1'b1, 64'h3333_0000_0000_0008, 2'd1, 1'b1);

        // Async reset while FULL
        in_valid = 1'b1;
        in_data  = 64'h4444_0000_0000_0009;
        step();
        in_valid = 1'b0;
        chk_out("rst.full", 1'b1, 64'h3333_0000_0000_0008, 2'd2, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        chk_out("rst.async", 1'b0, 64'h0, 2'd0, 1'b1);
        chk("rst.stall", 64'(stall_cnt), 64'd0);
        #1;
        nRST      = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 64'h5555_0000_0000_000A;
        step();
        chk_out("rst.first", 1'b1, 64'h5555_0000_0000_000A, 2'd1, 1'b1);
        in_valid = 1'b0;
        step();
        chk_out("rst.e", 1'b0, 64'h0, 2'd0, 1'b1);

        // Random traffic against a queue model
        q.delete();
        for (int i = 0; i < 10000; i++) begin
            ex_rdy = (q.size() < 2);
            chk("rnd.ready", 64'(in_ready), 64'(ex_rdy));
            chk("rnd.occ", 64'(occupancy), 64'(q.size()));
            chk("rnd.data", out_data, (q.size() > 0) ? q[0] : 64'h0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = {$urandom, $urandom};
            a = in_valid && ex_rdy;
            c = out_ready && (q.size() > 0);
            d = in_data;
            step();
            if (flush) begin
                q.delete();
            end else begin
                if (c) void'(q.pop_front());
                if (a) q.push_back(d);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_latch.md
PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 Parameter WIDTH, default 64, payload width in bits (packed {pc, instr} for the IF/ID use).
REQ-002 Parameter ZERO_BUBBLE, default 1: when 1, out_data SHALL read all zeros whenever out_valid=0.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 CLK  input  1  clock, all state updates on the rising edge.
REQ-005 nRST  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream holds a valid payload this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 in_ready  output  1  latch can accept a payload this cycle.
REQ-009 out_valid  output  1  out_data holds a valid payload.
REQ-010 out_data  output  WIDTH  oldest held payload.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 flush  input  1  discard all held and incoming payloads (branch or jump resolve).
REQ-013 occupancy  output  2  number of held entries, 0 to 2.
REQ-014 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Storage SHALL be a main entry (drives out_data) plus one skid entry, giving a 2-deep FIFO.
REQ-016 State machine SHALL have three states: EMPTY, ONE, FULL; occupancy SHALL be 0, 1 or 2 respectively.
REQ-017 Accept SHALL occur when in_valid and in_ready; consume SHALL occur when out_valid and out_ready.
REQ-018 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL; it SHALL be driven from state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL be 1 exactly when the state is ONE or FULL.
REQ-020 EMPTY with accept SHALL go to ONE; the payload is written into main and appears on out_data the next cycle (latency 1).
REQ-021 ONE with accept and no consume SHALL go to FULL, with the payload written into skid.
REQ-022 ONE with accept and consume SHALL stay in ONE, with the payload written into main.
REQ-023 ONE with consume only SHALL go to EMPTY.
REQ-024 FULL with consume SHALL go to ONE, with skid moved into main.
REQ-025 FULL without consume SHALL hold; no accept is possible in FULL.
REQ-026 Payload order SHALL be preserved, with no loss and no duplication.
REQ-027 Flush SHALL have priority over every event: on the next edge the state becomes EMPTY, any same-cycle accept is dropped, and stall_cnt is unaffected.
REQ-028 With ZERO_BUBBLE=1, the main entry SHALL also be zeroed on flush and on consume-to-EMPTY.
REQ-029 stall_cnt SHALL increment by 1 per stall cycle, saturate at all-ones, and never wrap.
REQ-030 Held payloads SHALL never change except through the transitions above.

Reset
REQ-031 Asserting nRST SHALL immediately set state to EMPTY, both entries to 0 and stall_cnt to 0.
REQ-032 Reset outputs SHALL be: out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
REQ-033 Reset in the middle of an operation SHALL discard all held payloads; the first accept after release SHALL follow the EMPTY rules.

Structure
REQ-034 cpu_types_pkg SHALL hold the state enum latch_state_t {EMPTY, ONE, FULL} and the constant IFID_W = 64.
REQ-035 The IF/ID instance SHALL use WIDTH=IFID_W with in_data = {pc, instr} (word_t each).
REQ-036 There SHALL be a single module with no sub-modules; state and entries are one registered process, and next-state and the ready/valid outputs are combinational.

Verification
REQ-037 Reset, then in_valid with 0x00000004_8C220000 and out_ready=1 -> out_valid=1 one cycle later, out_data=0x000000048C220000, occupancy=1.
REQ-038 out_ready=0, accept A then B -> occupancy=2 and in_ready=0; then out_ready=1 for 2 cycles -> out_data shows A then B, then out_valid=0 with out_data=0.
REQ-039 FULL, then flush=1 together with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_data=0, and the incoming payload never appears.
REQ-040 CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and holds at 15.
REQ-041 Random in_valid/out_ready for 10k cycles against a queue model -> output sequence equals input sequence minus flushed items, and no accept is ever seen while in_ready=0.
REQ-042 nRST pulsed low mid-cycle while FULL -> outputs reach reset values immediately without a clock edge; the first accept after release appears after 1 cycle.
